// File: rtl/game_tick_scheduler_pkg.sv
// Shared definitions for the game tick scheduler: FSM state encodings,
// default strobe periods and the test-mode period scaling rule.
package game_tick_scheduler_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam int unsigned DEF_PIX_PERIOD  = 4;
    localparam int unsigned DEF_SEG_PERIOD  = 200000;
    localparam int unsigned DEF_SEC_PERIOD  = 100000000;
    localparam int unsigned DEF_CHAR_PERIOD = 25000000;
    localparam int unsigned DEF_TEST_SCALE  = 1000;
    localparam int unsigned DEF_TIME_W      = 8;
    localparam int unsigned DEF_START_SECS  = 99;

    // Floored division, never below one cycle.
    function automatic int unsigned scaled_period(input int unsigned period,
                                                  input int unsigned scale);
        int unsigned q;
        q = (scale == 0) ? period : period / scale;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_gen.sv
// Clock-enable strobe generator: counts 0..P-1 while enabled and emits a
// registered one-cycle tick after the terminal count, wrapping on the same edge.
module tick_gen
    import game_tick_scheduler_pkg::*;
#(
    parameter int unsigned PERIOD     = 4,
    parameter int unsigned TEST_SCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic test_mode_i,
    output logic tick_o
);

    localparam int unsigned P_NORM = (PERIOD == 0) ? 1 : PERIOD;
    localparam int unsigned P_TEST = scaled_period(P_NORM, TEST_SCALE);
    localparam int unsigned CNT_W  = $clog2(P_NORM + 1);

    localparam logic [CNT_W-1:0] LAST_NORM = CNT_W'(P_NORM - 1);
    localparam logic [CNT_W-1:0] LAST_TEST = CNT_W'(P_TEST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;
    logic             tick_q, tick_d;

    // ">=" so a count left above a freshly shrunk period still terminates.
    always_comb begin
        last   = test_mode_i ? LAST_TEST : LAST_NORM;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q >= last) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timing controller: free-running pixel/scan strobes, RUN-gated second and
// character-move strobes, and the IDLE/RUN/PAUSED/EXPIRED round-timer FSM.
module game_tick_scheduler
    import game_tick_scheduler_pkg::*;
#(
    parameter int unsigned PIX_PERIOD  = DEF_PIX_PERIOD,
    parameter int unsigned SEG_PERIOD  = DEF_SEG_PERIOD,
    parameter int unsigned SEC_PERIOD  = DEF_SEC_PERIOD,
    parameter int unsigned CHAR_PERIOD = DEF_CHAR_PERIOD,
    parameter int unsigned TEST_SCALE  = DEF_TEST_SCALE,
    parameter int unsigned TIME_W      = DEF_TIME_W,
    parameter int unsigned START_SECS  = DEF_START_SECS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_mode_i,
    input  logic              start_i,
    input  logic              pause_i,
    output logic              pix_en_o,
    output logic              seg_en_o,
    output logic              sec_en_o,
    output logic              char_en_o,
    output logic [TIME_W-1:0] secs_left_o,
    output logic [1:0]        state_o,
    output logic              expired_o
);

    if (START_SECS == 0) begin : g_bad_start_secs
        $error("game_tick_scheduler: START_SECS must be non-zero");
    end
    if (START_SECS >= (64'd1 << TIME_W)) begin : g_bad_time_w
        $error("game_tick_scheduler: START_SECS does not fit in TIME_W bits");
    end

    localparam logic [TIME_W-1:0] START_VAL = TIME_W'(START_SECS);

    logic [1:0]        state_q, state_d;
    logic [TIME_W-1:0] secs_q, secs_d;
    logic              run;
    logic              sec_tick, char_tick;

    assign run = (state_q == ST_RUN);

    tick_gen #(.PERIOD(PIX_PERIOD), .TEST_SCALE(1)) u_pix (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .clr_i(1'b0),
        .test_mode_i(test_mode_i), .tick_o(pix_en_o)
    );

    tick_gen #(.PERIOD(SEG_PERIOD), .TEST_SCALE(TEST_SCALE)) u_seg (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(1'b1), .clr_i(1'b0),
        .test_mode_i(test_mode_i), .tick_o(seg_en_o)
    );

    tick_gen #(.PERIOD(SEC_PERIOD), .TEST_SCALE(TEST_SCALE)) u_sec (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(run), .clr_i(start_i),
        .test_mode_i(test_mode_i), .tick_o(sec_tick)
    );

    tick_gen #(.PERIOD(CHAR_PERIOD), .TEST_SCALE(TEST_SCALE)) u_char (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(run), .clr_i(start_i),
        .test_mode_i(test_mode_i), .tick_o(char_tick)
    );

    // start outranks everything; a pause coinciding with a non-final second
    // tick still takes the decrement.
    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        if (start_i) begin
            state_d = ST_RUN;
            secs_d  = START_VAL;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (sec_tick) begin
                        if (secs_q <= TIME_W'(1)) begin
                            state_d = ST_EXPIRED;
                            secs_d  = '0;
                        end else begin
                            secs_d = secs_q - TIME_W'(1);
                            if (pause_i) state_d = ST_PAUSED;
                        end
                    end else if (pause_i) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (pause_i) state_d = ST_RUN;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            secs_q  <= '0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
        end
    end

    assign sec_en_o    = sec_tick;
    assign char_en_o   = char_tick;
    assign secs_left_o = secs_q;
    assign state_o     = state_q;
    assign expired_o   = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed scenarios with literal expectations,
// then randomized stimulus, all outputs compared every cycle against a model.
module tb_game_tick_scheduler;
    import game_tick_scheduler_pkg::*;

    localparam int PIX = 4, SEG = 10, SEC = 20, CHR = 5, SCALE = 5, TW = 8, SS = 3;

    logic          clk = 1'b0;
    logic          rst_n, tm, start, pause;
    logic          pix_en, seg_en, sec_en, char_en, expired;
    logic [TW-1:0] secs_left;
    logic [1:0]    state;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .PIX_PERIOD(PIX), .SEG_PERIOD(SEG), .SEC_PERIOD(SEC), .CHAR_PERIOD(CHR),
        .TEST_SCALE(SCALE), .TIME_W(TW), .START_SECS(SS)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .test_mode_i(tm), .start_i(start), .pause_i(pause),
        .pix_en_o(pix_en), .seg_en_o(seg_en), .sec_en_o(sec_en), .char_en_o(char_en),
        .secs_left_o(secs_left), .state_o(state), .expired_o(expired)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Strobe i fires once every P_i active cycles; timer states as plain ints.
    int m_cnt[4];
    bit m_tick[4];
    int m_state;
    int m_secs;
    bit m_valid = 1'b0;

    function automatic int eff(input int idx, input bit t);
        int base;
        int q;
        case (idx)
            0:       base = PIX;
            1:       base = SEG;
            2:       base = SEC;
            default: base = CHR;
        endcase
        if (idx == 0 || !t) return base;
        q = base / SCALE;
        return (q < 1) ? 1 : q;
    endfunction

    always @(posedge clk) begin : model
        bit was_run;
        bit sec_seen;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = 0;
                m_tick[i] = 1'b0;
            end
            m_state = 0;
            m_secs  = 0;
            m_valid = 1'b1;
        end else begin
            was_run  = (m_state == 1);
            sec_seen = m_tick[2];
            for (int i = 0; i < 4; i++) begin
                if (i >= 2 && start) begin
                    m_cnt[i]  = 0;
                    m_tick[i] = 1'b0;
                end else if (i < 2 || was_run) begin
                    if (m_cnt[i] >= eff(i, tm) - 1) begin
                        m_cnt[i]  = 0;
                        m_tick[i] = 1'b1;
                    end else begin
                        m_cnt[i]  = m_cnt[i] + 1;
                        m_tick[i] = 1'b0;
                    end
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
            if (start) begin
                m_state = 1;
                m_secs  = SS;
            end else if (m_state == 1) begin
                if (sec_seen) begin
                    if (m_secs <= 1) begin
                        m_state = 3;
                        m_secs  = 0;
                    end else begin
                        m_secs = m_secs - 1;
                        if (pause) m_state = 2;
                    end
                end else if (pause) begin
                    m_state = 2;
                end
            end else if (m_state == 2 && pause) begin
                m_state = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pix_en",    int'(pix_en),    int'(m_tick[0]));
            chk("seg_en",    int'(seg_en),    int'(m_tick[1]));
            chk("sec_en",    int'(sec_en),    int'(m_tick[2]));
            chk("char_en",   int'(char_en),   int'(m_tick[3]));
            chk("state",     int'(state),     m_state);
            chk("secs_left", int'(secs_left), m_secs);
            chk("expired",   int'(expired),   (m_state == 3) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
    endtask

    initial begin
        int n_pix, n_seg, n_sc, k, first_sec, first_char, exp_k;
        rst_n = 1'b0; tm = 1'b0; start = 1'b0; pause = 1'b0;

        // Reset and free-running strobes
        step(3);
        chk("rst_state", int'(state), 0);
        chk("rst_secs", int'(secs_left), 0);
        chk("rst_strobes", int'({pix_en, seg_en, sec_en, char_en}), 0);
        chk("rst_expired", int'(expired), 0);
        rst_n = 1'b1;
        n_pix = 0; n_seg = 0; n_sc = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            n_pix += int'(pix_en);
            n_seg += int'(seg_en);
            n_sc  += int'(sec_en) + int'(char_en);
        end
        chk("idle_pix_count", n_pix, 25);
        chk("idle_seg_count", n_seg, 10);
        chk("idle_run_strobes", n_sc, 0);

        // Full round to expiry
        pulse_start();
        chk("start_state", int'(state), 1);
        chk("start_secs", int'(secs_left), 3);
        first_sec = 0; first_char = 0; exp_k = 0;
        for (k = 1; k <= 300; k++) begin
            step(1);
            if (char_en && first_char == 0) first_char = k;
            if (sec_en && first_sec == 0) first_sec = k;
            if (state == 2'd3) begin
                exp_k = k;
                break;
            end
        end
        chk("first_char_latency", first_char, 5);
        chk("first_sec_latency", first_sec, 20);
        chk("expire_cycle", exp_k, 61);
        chk("expire_secs", int'(secs_left), 0);
        chk("expire_flag", int'(expired), 1);
        n_sc = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            n_sc += int'(sec_en) + int'(char_en);
        end
        chk("expired_strobes", n_sc, 0);

        // Pause and resume
        pulse_start();
        step(6);
        pulse_pause();
        chk("paused_state", int'(state), 2);
        n_sc = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            n_sc += int'(sec_en) + int'(char_en);
        end
        chk("paused_strobes", n_sc, 0);
        pulse_pause();
        chk("resume_state", int'(state), 1);
        first_sec = 0;
        for (k = 1; k <= 100; k++) begin
            step(1);
            if (sec_en) begin
                first_sec = k;
                break;
            end
        end
        chk("resume_sec_latency", first_sec, 13);

        // start + pause together, then start on the final second tick
        step(3);
        start = 1'b1; pause = 1'b1;
        step(1);
        start = 1'b0; pause = 1'b0;
        chk("start_pause_state", int'(state), 1);
        chk("start_pause_secs", int'(secs_left), 3);
        first_sec = 0;
        for (k = 1; k <= 100; k++) begin
            step(1);
            if (sec_en) begin
                first_sec = k;
                break;
            end
        end
        chk("restart_sec_latency", first_sec, 20);
        exp_k = 0;
        for (k = 1; k <= 100; k++) begin
            step(1);
            if (sec_en && secs_left == TW'(1)) begin
                exp_k = k;
                break;
            end
        end
        chk("final_tick_found", (exp_k != 0) ? 1 : 0, 1);
        pulse_start();
        chk("start_beats_expire_state", int'(state), 1);
        chk("start_beats_expire_secs", int'(secs_left), 3);

        // test_mode switch with sec count at 10
        step(10);
        tm = 1'b1;
        step(1);
        chk("tm_switch_sec", int'(sec_en), 1);
        n_sc = 0; first_sec = 0;
        for (k = 1; k <= 20; k++) begin
            step(1);
            n_sc += int'(char_en);
            if (sec_en) begin
                first_sec = k;
                break;
            end
        end
        chk("tm_sec_period", first_sec, 4);
        chk("tm_char_count", n_sc, 4);
        for (k = 1; k <= 20 && !seg_en; k++) step(1);
        first_sec = 0;
        for (k = 1; k <= 20; k++) begin
            step(1);
            if (seg_en) begin
                first_sec = k;
                break;
            end
        end
        chk("tm_seg_period", first_sec, 2);
        tm = 1'b0;

        // Reset mid-RUN
        pulse_start();
        for (k = 1; k <= 100 && secs_left != TW'(2); k++) step(1);
        chk("pre_reset_secs", int'(secs_left), 2);
        rst_n = 1'b0;
        step(1);
        chk("midrun_rst_state", int'(state), 0);
        chk("midrun_rst_secs", int'(secs_left), 0);
        chk("midrun_rst_strobes", int'({pix_en, seg_en, sec_en, char_en}), 0);
        rst_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 40) == 0;
            pause = ($urandom % 12) == 0;
            if (($urandom % 300) == 0) tm = ~tm;
            rst_n = ($urandom % 1500) != 0;
            step(1);
        end
        start = 1'b0; pause = 1'b0; rst_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
